wave_drawer_datapath: RTL and testbench



---
 rtl/wave_drawer_datapath.sv | 188 ++++++++++++++++++
 tb/tb_wave_drawer_datapath.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wave_drawer_datapath.sv
`default_nettype none
// ============================================================================
// Module   : wave_drawer_datapath
// Purpose  : Column sweep datapath for the wave drawer (draw/erase/idle hold)
// Revision : 1.0 - initial release
// ============================================================================
module wave_drawer_datapath #(
    parameter int WIDTH    = 640,
    parameter int HEIGHT   = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int SAMPLE_W = 24,
    parameter int SHIFT    = 16,
    parameter int DURATION = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic                       draw,
    input  logic                       idle,
    input  logic                       erase,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic [X_W-1:0]             pixel_x,
    output logic [Y_W-1:0]             pixel_y,
    output logic                       pixel_color,
    output logic                       pixel_write,
    output logic                       done,
    output logic                       invalidate
);

    localparam int c_cnt_w = $clog2(DURATION + 2);
    localparam int c_a_w   = $clog2(WIDTH);

    localparam logic [X_W-1:0]            c_x_max   = X_W'(WIDTH - 1);
    localparam logic [X_W-1:0]            c_x_last  = X_W'(1);
    localparam logic [c_cnt_w-1:0]        c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]        c_cnt_dur = c_cnt_w'(DURATION);
    localparam logic [c_cnt_w-1:0]        c_cnt_sat = c_cnt_w'(DURATION + 1);
    localparam logic signed [SAMPLE_W:0]  c_half    = (SAMPLE_W + 1)'(HEIGHT / 2);
    localparam logic signed [SAMPLE_W:0]  c_y_max   = (SAMPLE_W + 1)'(HEIGHT - 1);

    localparam logic [1:0] c_mode_init  = 2'd0;
    localparam logic [1:0] c_mode_erase = 2'd1;
    localparam logic [1:0] c_mode_draw  = 2'd2;
    localparam logic [1:0] c_mode_idle  = 2'd3;

    logic [1:0]               r_prev_mode;
    logic [X_W-1:0]           r_x;
    logic                     r_fin;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [Y_W-1:0]           r_y_mem [WIDTH];
    logic                     r_rd_valid;
    logic [X_W-1:0]           r_rd_x;
    logic [Y_W-1:0]           r_rd_y;
    logic                     r_rd_last;
    logic [X_W-1:0]           r_pixel_x;
    logic [Y_W-1:0]           r_pixel_y;
    logic                     r_pixel_color;
    logic                     r_pixel_write;
    logic                     r_done;
    logic                     r_invalidate;

    logic [1:0]               w_mode;
    logic                     w_restart;
    logic [X_W-1:0]           w_x_cur;
    logic                     w_fin_cur;
    logic [c_cnt_w-1:0]       w_cnt_cur;
    logic                     w_ready;
    logic                     w_accept;
    logic                     w_issue;
    logic [c_a_w-1:0]         w_addr;
    logic signed [SAMPLE_W:0] w_shifted;
    logic signed [SAMPLE_W:0] w_diff;
    logic [Y_W-1:0]           w_y_new;

    always_comb begin
        w_mode = c_mode_init;
        if (init)       w_mode = c_mode_init;
        else if (erase) w_mode = c_mode_erase;
        else if (draw)  w_mode = c_mode_draw;
        else if (idle)  w_mode = c_mode_idle;
    end

    // A mode change restarts the sweep within the same cycle, so the first
    // DRAW/ERASE cycle already works on column WIDTH-1.
    assign w_restart = (w_mode != r_prev_mode) || (w_mode == c_mode_init);
    assign w_x_cur   = w_restart ? c_x_max : r_x;
    assign w_fin_cur = w_restart ? 1'b0 : r_fin;
    assign w_cnt_cur = w_restart ? '0 : r_cnt;

    assign w_ready  = reset && (w_mode == c_mode_draw) && !w_fin_cur;
    assign w_accept = w_ready && sample_valid;
    assign w_issue  = reset && (w_mode == c_mode_erase) && !w_fin_cur;
    assign w_addr   = w_x_cur[c_a_w-1:0];

    assign w_shifted = $signed({sample[SAMPLE_W-1], sample}) >>> SHIFT;
    assign w_diff    = c_half - w_shifted;

    always_comb begin
        w_y_new = Y_W'(w_diff);
        if (w_diff[SAMPLE_W])
            w_y_new = '0;
        else if (w_diff > c_y_max)
            w_y_new = Y_W'(c_y_max);
    end

    // Column memory is deliberately not reset; a DRAW always precedes ERASE.
    always_ff @(posedge clk) begin
        if (w_accept)
            r_y_mem[w_addr] <= w_y_new;
        if (w_issue)
            r_rd_y <= r_y_mem[w_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_mode   <= c_mode_init;
            r_x           <= c_x_max;
            r_fin         <= 1'b0;
            r_cnt         <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_x        <= '0;
            r_rd_last     <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_pixel_color <= 1'b0;
            r_pixel_write <= 1'b0;
            r_done        <= 1'b0;
            r_invalidate  <= 1'b0;
        end else begin
            r_prev_mode <= w_mode;
            r_x         <= w_x_cur;
            r_fin       <= w_fin_cur;
            if (w_accept || w_issue) begin
                if (w_x_cur == c_x_last)
                    r_fin <= 1'b1;
                else
                    r_x <= w_x_cur - c_x_last;
            end

            if (w_mode == c_mode_idle) begin
                if (w_cnt_cur != c_cnt_sat)
                    r_cnt <= w_cnt_cur + c_cnt_one;
                else
                    r_cnt <= w_cnt_cur;
            end else begin
                r_cnt <= '0;
            end
            r_invalidate <= (w_mode == c_mode_idle) && (w_cnt_cur > c_cnt_dur);

            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_x    <= w_x_cur;
                r_rd_last <= (w_x_cur == c_x_last);
            end

            // A read still in flight when ERASE is left is dropped.
            if (w_accept) begin
                r_pixel_write <= 1'b1;
                r_pixel_x     <= w_x_cur;
                r_pixel_y     <= w_y_new;
                r_pixel_color <= 1'b1;
                r_done        <= (w_x_cur == c_x_last);
            end else if (r_rd_valid && (w_mode == c_mode_erase)) begin
                r_pixel_write <= 1'b1;
                r_pixel_x     <= r_rd_x;
                r_pixel_y     <= r_rd_y;
                r_pixel_color <= 1'b0;
                r_done        <= r_rd_last;
            end else begin
                r_pixel_write <= 1'b0;
                r_done        <= 1'b0;
            end
        end
    end

    assign sample_ready = w_ready;
    assign pixel_x      = r_pixel_x;
    assign pixel_y      = r_pixel_y;
    assign pixel_color  = r_pixel_color;
    assign pixel_write  = r_pixel_write;
    assign done         = r_done;
    assign invalidate   = r_invalidate;

endmodule
`default_nettype wire

// File: tb/tb_wave_drawer_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_drawer_datapath
// Purpose  : Directed self-checking bench for wave_drawer_datapath
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_drawer_datapath;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              init = 1'b0;
    logic              draw = 1'b1;
    logic              idle = 1'b0;
    logic              erase = 1'b0;
    logic signed [7:0] sample = 8'sd5;
    logic              sample_valid = 1'b1;
    logic              sample_ready;
    logic [9:0]        pixel_x;
    logic [8:0]        pixel_y;
    logic              pixel_color;
    logic              pixel_write;
    logic              done;
    logic              invalidate;

    int n_checks = 0;
    int n_errors = 0;

    wave_drawer_datapath #(
        .WIDTH(8), .HEIGHT(8), .X_W(10), .Y_W(9),
        .SAMPLE_W(8), .SHIFT(0), .DURATION(3)
    ) dut (
        .clk(clk), .reset(reset),
        .init(init), .draw(draw), .idle(idle), .erase(erase),
        .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
        .pixel_write(pixel_write), .done(done), .invalidate(invalidate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks outputs mid-cycle, then advances to just after the next rising edge.
    task automatic step_chk(input string tag, input logic exp_pw, input int exp_x,
                            input int exp_y, input logic exp_col, input logic exp_done,
                            input int exp_ready);
        @(negedge clk);
        chk({tag, "_write"}, 32'(pixel_write), 32'(exp_pw));
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        if (exp_ready >= 0)
            chk({tag, "_ready"}, 32'(sample_ready), 32'(exp_ready));
        if (exp_pw) begin
            chk({tag, "_x"}, 32'(pixel_x), 32'(exp_x));
            chk({tag, "_y"}, 32'(pixel_y), 32'(exp_y));
            chk({tag, "_color"}, 32'(pixel_color), 32'(exp_col));
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_write"}, 32'(pixel_write), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ready"}, 32'(sample_ready), 32'd0);
        chk({tag, "_inval"}, 32'(invalidate), 32'd0);
        chk({tag, "_x"}, 32'(pixel_x), 32'd0);
        chk({tag, "_y"}, 32'(pixel_y), 32'd0);
        chk({tag, "_color"}, 32'(pixel_color), 32'd0);
    endtask

    initial begin
        // Reset held with draw and sample_valid active
        #1;
        chk("rst_t0_ready", 32'(sample_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");

        // Release into INIT for two cycles
        @(posedge clk); #1;
        reset = 1'b1; init = 1'b1; draw = 1'b0; sample_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // DRAW sweep with a three-cycle stall after column 4 is accepted
        init = 1'b0; draw = 1'b1; sample_valid = 1'b1;
        sample = 8'sd0;   step_chk("d1",  0, 0, 0, 1, 0, 1);
        sample = 8'sd1;   step_chk("d2",  1, 7, 4, 1, 0, 1);
        sample = -8'sd1;  step_chk("d3",  1, 6, 3, 1, 0, 1);
        sample = 8'sd4;   step_chk("d4",  1, 5, 5, 1, 0, 1);
        sample_valid = 1'b0;
        sample = 8'sd100; step_chk("d5",  1, 4, 0, 1, 0, 1);
                          step_chk("d6",  0, 0, 0, 1, 0, 1);
                          step_chk("d7",  0, 0, 0, 1, 0, 1);
        sample_valid = 1'b1;
        sample = -8'sd4;  step_chk("d8",  0, 0, 0, 1, 0, 1);
        sample = 8'sd2;   step_chk("d9",  1, 3, 7, 1, 0, 1);
        sample = 8'sd3;   step_chk("d10", 1, 2, 2, 1, 0, 1);
        sample = 8'sd5;   step_chk("d11", 1, 1, 1, 1, 1, 0);
                          step_chk("d12", 0, 0, 0, 1, 0, 0);

        // IDLE hold for eight cycles
        draw = 1'b0; idle = 1'b1; sample_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("idle_c%0d_inval", c), 32'(invalidate), (c >= 6) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end

        // ERASE sweep straight out of IDLE
        idle = 1'b0; erase = 1'b1;
        @(negedge clk);
        chk("e1_write", 32'(pixel_write), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_drop_inval", 32'(invalidate), 32'd0);
        chk("e2_write", 32'(pixel_write), 32'd0);
        @(posedge clk); #1;
        step_chk("e3", 1, 7, 4, 0, 0, 0);
        step_chk("e4", 1, 6, 3, 0, 0, 0);
        step_chk("e5", 1, 5, 5, 0, 0, 0);
        step_chk("e6", 1, 4, 0, 0, 0, 0);
        step_chk("e7", 1, 3, 7, 0, 0, 0);
        step_chk("e8", 1, 2, 2, 0, 0, 0);
        step_chk("e9", 1, 1, 1, 0, 1, 0);

        // ERASE directly into DRAW restarts at column 7
        erase = 1'b0; draw = 1'b1; sample_valid = 1'b1;
        sample = 8'sd0; step_chk("ed1", 0, 0, 0, 1, 0, -1);
        sample = 8'sd1; step_chk("ed2", 1, 7, 4, 1, 0, 1);
        sample = 8'sd2; step_chk("ed3", 1, 6, 3, 1, 0, 1);

        // Asynchronous reset between edges while column 4 is presented
        sample = 8'sd3;
        #1;
        chk("pre_rst_write", 32'(pixel_write), 32'd1);
        chk("pre_rst_x", 32'(pixel_x), 32'd5);
        chk("pre_rst_y", 32'(pixel_y), 32'd2);
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk); #1;
        reset = 1'b1; sample = 8'sd0;
        step_chk("r1", 0, 0, 0, 1, 0, 1);
        step_chk("r2", 1, 7, 4, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
